// File: rtl/pll_phase_pkg.sv
// Shared types and parameter defaults for the PLL dynamic-phase controller.
package pll_phase_pkg;

    localparam int PULSE_W_DEF      = 4;
    localparam int STEP_GAP_DEF     = 8;
    localparam int LOCK_FILT_DEF    = 1024;
    localparam int LOCK_TIMEOUT_DEF = 65535;
    localparam int RST_W_DEF        = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP_LO,
        STEP_HI,
        WAIT_LOCK,
        PLL_RST
    } state_e;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_filt.sv
// Synchronizes the asynchronous PLL lock and requires LOCK_FILT consecutive
// locked cycles before reporting lock_stable.
module pll_lock_filt
    import pll_phase_pkg::*;
#(
    parameter int LOCK_FILT = LOCK_FILT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    input  logic pll_rst,
    output logic lock_stable
);

    localparam int FW = $clog2(LOCK_FILT + 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [FW-1:0] filt_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, which is what makes the two stages a chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pll_lock;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
        end else if (!sync_q2 || pll_rst) begin
            filt_cnt <= '0;
        end else if (filt_cnt != FW'(LOCK_FILT)) begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign lock_stable = (filt_cnt == FW'(LOCK_FILT));

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequences PLL dynamic phase steps, then waits for relock, resetting the PLL
// whenever relock takes longer than LOCK_TIMEOUT cycles.
module pll_phase_ctrl
    import pll_phase_pkg::*;
#(
    parameter int PULSE_W      = PULSE_W_DEF,
    parameter int STEP_GAP     = STEP_GAP_DEF,
    parameter int LOCK_FILT    = LOCK_FILT_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
    parameter int RST_W        = RST_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_steps,
    input  logic       rst_req,
    output logic [2:0] phase_sel,
    output logic       phase_dir,
    output logic       phase_step_n,
    output logic       pll_rst,
    output logic       lock_stable,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_W = $clog2(max_of4(PULSE_W, STEP_GAP, LOCK_TIMEOUT, RST_W) + 1);

    state_e             state;
    state_e             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         remaining;
    logic               pending;
    logic               accept;

    pll_lock_filt #(.LOCK_FILT(LOCK_FILT)) u_lock_filt (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .pll_rst     (pll_rst),
        .lock_stable (lock_stable)
    );

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PLL_RST;
        else        state <= state_next;
    end

    // NOTE: state_next gets a default first so no path through the case can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (rst_req)                         state_next = PLL_RST;
                else if (!lock_stable)               state_next = WAIT_LOCK;
                else if (accept && req_steps != '0)  state_next = SETUP;
            end
            SETUP:   state_next = STEP_LO;
            STEP_LO: if (cnt == CNT_W'(PULSE_W - 1)) state_next = STEP_HI;
            STEP_HI: begin
                if (cnt == CNT_W'(STEP_GAP - 1))
                    state_next = (remaining != '0) ? STEP_LO : WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_stable)                           state_next = IDLE;
                else if (cnt == CNT_W'(LOCK_TIMEOUT - 1))  state_next = PLL_RST;
            end
            PLL_RST: if (cnt == CNT_W'(RST_W - 1)) state_next = WAIT_LOCK;
            default: state_next = PLL_RST;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        pll_rst      = (state == PLL_RST);
        phase_step_n = (state != STEP_LO);
        req_ready    = (state == IDLE) && lock_stable && !rst_req;
    end

    // One shared cycle counter restarts on every state change; the timeout
    // therefore restarts from zero each time PLL_RST hands back to WAIT_LOCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            remaining <= '0;
            phase_sel <= '0;
            phase_dir <= 1'b0;
            pending   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (state_next != state || state == IDLE) cnt <= '0;
            else                                      cnt <= cnt + CNT_W'(1);

            if (accept) begin
                phase_sel <= req_sel;
                phase_dir <= req_dir;
                remaining <= req_steps;
                pending   <= (req_steps != '0);
                done      <= (req_steps == '0);
            end

            if (state == STEP_LO && state_next == STEP_HI)
                remaining <= remaining - 8'd1;

            if (state == WAIT_LOCK && state_next == IDLE) begin
                done    <= pending;
                pending <= 1'b0;
            end

            if (state == WAIT_LOCK && state_next == PLL_RST)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scenario bench for pll_phase_ctrl: expected output events are queued with
// the cycle they must appear in and matched as the DUT produces them.
module tb_pll_phase_ctrl;

    localparam int PULSE_W      = 2;
    localparam int STEP_GAP     = 3;
    localparam int LOCK_FILT    = 8;
    localparam int LOCK_TIMEOUT = 100;
    localparam int RST_W        = 4;
    localparam int STEP_PERIOD  = PULSE_W + STEP_GAP;

    typedef enum {EV_DONE, EV_ERR, EV_RST, EV_STEP} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        int         cyc;
        logic [3:0] data;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_sel;
    logic       req_dir;
    logic [7:0] req_steps;
    logic       rst_req;
    logic [2:0] phase_sel;
    logic       phase_dir;
    logic       phase_step_n;
    logic       pll_rst;
    logic       lock_stable;
    logic       busy;
    logic       done;
    logic       err;

    ev_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic prev_rst  = 1'b1;
    logic prev_step = 1'b1;
    int   rst_rise_cyc  = 0;
    int   step_fall_cyc = 0;

    // {pll_rst, phase_step_n, phase_sel, phase_dir, done, err, lock_stable, busy, req_ready}
    localparam logic [10:0] RESET_VEC = 11'b1_1_000_0_0_0_0_1_0;

    pll_phase_ctrl #(
        .PULSE_W      (PULSE_W),
        .STEP_GAP     (STEP_GAP),
        .LOCK_FILT    (LOCK_FILT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .RST_W        (RST_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sel      (req_sel),
        .req_dir      (req_dir),
        .req_steps    (req_steps),
        .rst_req      (rst_req),
        .phase_sel    (phase_sel),
        .phase_dir    (phase_dir),
        .phase_step_n (phase_step_n),
        .pll_rst      (pll_rst),
        .lock_stable  (lock_stable),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_ev(input ev_kind_e k, input int c, input logic [3:0] d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e k, input logic [3:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d data %h, required none", k.name(), cyc, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.cyc !== cyc || e.data !== d) begin
                errors++;
                $display("FAIL event: got %s cyc %0d data %h, required %s cyc %0d data %h",
                         k.name(), cyc, d, e.kind.name(), e.cyc, e.data);
            end
        end
    endtask

    task automatic monitor();
        ev_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: %s never seen, required at cycle %0d", e.kind.name(), e.cyc);
        end
        if (done) observe(EV_DONE, 4'h0);
        if (err)  observe(EV_ERR, 4'h0);
        if (pll_rst && !prev_rst) begin
            observe(EV_RST, 4'h0);
            rst_rise_cyc = cyc;
        end
        if (!pll_rst && prev_rst) begin
            checks++;
            if (cyc - rst_rise_cyc !== RST_W) begin
                errors++;
                $display("FAIL pll_rst_width: got %0d, required %0d", cyc - rst_rise_cyc, RST_W);
            end
        end
        if (!phase_step_n && prev_step) begin
            observe(EV_STEP, {phase_dir, phase_sel});
            step_fall_cyc = cyc;
        end
        if (phase_step_n && !prev_step) begin
            checks++;
            if (cyc - step_fall_cyc !== PULSE_W) begin
                errors++;
                $display("FAIL step_low_width: got %0d, required %0d", cyc - step_fall_cyc, PULSE_W);
            end
        end
        prev_rst  = pll_rst;
        prev_step = phase_step_n;
    endtask

    // Advance one clock: inputs change at the falling edge, outputs are
    // sampled there too, half a period away from the capturing edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic issue(input logic [2:0] sel, input logic dir, input logic [7:0] steps,
                         input logic ready_exp);
        req_valid = 1'b1;
        req_sel   = sel;
        req_dir   = dir;
        req_steps = steps;
        #1;
        checks++;
        if (req_ready !== ready_exp) begin
            errors++;
            $display("FAIL req_ready_at_issue: got %b, required %b", req_ready, ready_exp);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        int lock_cyc  = -1;
        int ready_cyc = -1;
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({pll_rst, phase_step_n, phase_sel, phase_dir, done, err, lock_stable, busy, req_ready} !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required %b",
                     {pll_rst, phase_step_n, phase_sel, phase_dir, done, err, lock_stable, busy, req_ready}, RESET_VEC);
        end
        rst_n        = 1'b1;
        cyc          = 0;
        prev_rst     = 1'b1;
        prev_step    = 1'b1;
        rst_rise_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cyc == 20) pll_lock = 1'b1;
            if (lock_stable && lock_cyc < 0) lock_cyc = cyc;
            if (req_ready && ready_cyc < 0) ready_cyc = cyc;
        end
        checks++;
        if (lock_cyc !== 20 + 2 + LOCK_FILT) begin
            errors++;
            $display("FAIL powerup_lock_stable_cycle: got %0d, required %0d", lock_cyc, 20 + 2 + LOCK_FILT);
        end
        checks++;
        if (ready_cyc !== 20 + 2 + LOCK_FILT + 1) begin
            errors++;
            $display("FAIL powerup_ready_cycle: got %0d, required %0d", ready_cyc, 20 + 2 + LOCK_FILT + 1);
        end
    endtask

    task automatic test_step_op();
        int a = cyc + 1;
        int busy_bad = 0;
        int sel_bad  = 0;
        for (int i = 0; i < 3; i++) expect_ev(EV_STEP, a + 1 + i * STEP_PERIOD, 4'b1_010);
        expect_ev(EV_DONE, a + 1 + 3 * STEP_PERIOD + 1, 4'h0);
        issue(3'd2, 1'b1, 8'd3, 1'b1);
        for (int i = 0; i < 22; i++) begin
            if (busy !== (cyc <= a + 3 * STEP_PERIOD + 1)) busy_bad++;
            if (busy && {phase_dir, phase_sel} !== 4'b1_010) sel_bad++;
            tick();
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL step_op_busy_window: got %0d bad cycles, required 0", busy_bad);
        end
        checks++;
        if (sel_bad !== 0) begin
            errors++;
            $display("FAIL step_op_sel_stable: got %0d bad cycles, required 0", sel_bad);
        end
    endtask

    task automatic test_zero_steps();
        int a = cyc + 1;
        int busy_cnt = 0;
        expect_ev(EV_DONE, a, 4'h0);
        issue(3'd1, 1'b0, 8'd0, 1'b1);
        if (busy) busy_cnt++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        checks++;
        if (busy_cnt !== 0) begin
            errors++;
            $display("FAIL zero_steps_busy: got %0d busy cycles, required 0", busy_cnt);
        end
    endtask

    task automatic test_timeout_retry();
        int a = cyc + 1;
        int wl = a + 1 + STEP_PERIOD;
        int relock = wl + LOCK_TIMEOUT + RST_W + 5;
        pll_lock = 1'b0;
        expect_ev(EV_STEP, a + 1, 4'b0_100);
        expect_ev(EV_ERR, wl + LOCK_TIMEOUT, 4'h0);
        expect_ev(EV_RST, wl + LOCK_TIMEOUT, 4'h0);
        expect_ev(EV_DONE, relock + 2 + LOCK_FILT + 1, 4'h0);
        issue(3'd4, 1'b0, 8'd1, 1'b1);
        while (cyc < relock) tick();
        pll_lock = 1'b1;
        while (cyc < relock + 2 + LOCK_FILT + 4) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_return_idle: busy got %b, required 0", busy);
        end
    endtask

    task automatic test_rst_req_priority();
        int a = cyc + 1;
        int idle_cyc = -1;
        rst_req = 1'b1;
        expect_ev(EV_RST, a, 4'h0);
        issue(3'd3, 1'b1, 8'd5, 1'b0);
        rst_req = 1'b0;
        for (int i = 0; i < 40 && idle_cyc < 0; i++) begin
            tick();
            if (!busy) idle_cyc = cyc;
        end
        checks++;
        if (idle_cyc !== a + RST_W + LOCK_FILT + 1) begin
            errors++;
            $display("FAIL rst_req_idle_cycle: got %0d, required %0d", idle_cyc, a + RST_W + LOCK_FILT + 1);
        end
        checks++;
        if ({phase_dir, phase_sel} !== 4'b0_100) begin
            errors++;
            $display("FAIL rst_req_not_latched: got %h, required %h", {phase_dir, phase_sel}, 4'b0_100);
        end
    endtask

    task automatic test_reset_mid_op();
        int a = cyc + 1;
        int r;
        int lock_cyc  = -1;
        int ready_cyc = -1;
        expect_ev(EV_STEP, a + 1, 4'b1_001);
        expect_ev(EV_STEP, a + 1 + STEP_PERIOD, 4'b1_001);
        issue(3'd1, 1'b1, 8'd3, 1'b1);
        while (cyc < a + 1 + STEP_PERIOD + PULSE_W) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pll_rst, phase_step_n, phase_sel, phase_dir, done, err, lock_stable, busy, req_ready} !== RESET_VEC) begin
            errors++;
            $display("FAIL midop_reset_outputs: got %b, required %b",
                     {pll_rst, phase_step_n, phase_sel, phase_dir, done, err, lock_stable, busy, req_ready}, RESET_VEC);
        end
        prev_rst = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        r = cyc;
        rst_rise_cyc = r;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (lock_stable && lock_cyc < 0) lock_cyc = cyc;
            if (req_ready && ready_cyc < 0) ready_cyc = cyc;
        end
        checks++;
        if (lock_cyc !== r + RST_W + LOCK_FILT) begin
            errors++;
            $display("FAIL midop_relock_cycle: got %0d, required %0d", lock_cyc, r + RST_W + LOCK_FILT);
        end
        checks++;
        if (ready_cyc !== r + RST_W + LOCK_FILT + 1) begin
            errors++;
            $display("FAIL midop_ready_cycle: got %0d, required %0d", ready_cyc, r + RST_W + LOCK_FILT + 1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        pll_lock  = 1'b0;
        req_valid = 1'b0;
        req_sel   = '0;
        req_dir   = 1'b0;
        req_steps = '0;
        rst_req   = 1'b0;

        test_reset();
        test_step_op();
        test_zero_steps();
        test_timeout_retry();
        test_rst_req_priority();
        test_reset_mid_op();

        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
